// File: rtl/serializer_ctrl.sv
// serializer_ctrl: load sequencer for a group of PISO serializers sharing one
// serial clock. Words arrive on a valid/ready handshake into a 2-entry FIFO;
// every WIDTH clocks one word is presented on o_load_data with an o_load
// strobe that drives every channel's serializer write enable.
//
// Optional feature macro: SERIALIZER_CTRL_UNDERRUN_EN
//   defined   : an empty pop loads IDLE_WORD on every channel and sets the
//               sticky o_underrun flag (cleared by i_underrun_clr).
//   undefined : an empty pop repeats the previous load word; o_underrun is 0.
//
// Ports:
//   clk            serial clock, all logic on posedge
//   rst            asynchronous active-high reset
//   i_enable       run request
//   i_s_valid      input word valid
//   o_s_ready      FIFO can accept (decoded from registered state/count)
//   i_s_data       input word, channel c at [c*WIDTH +: WIDTH]
//   o_load         serializer write strobe, one cycle per WIDTH in RUN
//   o_load_data    word for the serializers, same packing as i_s_data
//   o_phase        bit phase, 0 on the load cycle
//   o_underrun     sticky empty-pop flag
//   i_underrun_clr clears o_underrun
module serializer_ctrl #(
   parameter int unsigned       WIDTH     = 10,
   parameter int unsigned       CHANNELS  = 3,
   parameter logic [WIDTH-1:0]  IDLE_WORD = 10'b1101010100
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_enable,
   input  logic                         i_s_valid,
   output logic                         o_s_ready,
   input  logic [CHANNELS*WIDTH-1:0]    i_s_data,
   output logic                         o_load,
   output logic [CHANNELS*WIDTH-1:0]    o_load_data,
   output logic [$clog2(WIDTH)-1:0]     o_phase,
   output logic                         o_underrun,
   input  logic                         i_underrun_clr
);

   localparam int unsigned DW = CHANNELS * WIDTH;
   localparam int unsigned PW = $clog2(WIDTH);

   localparam logic [DW-1:0] IDLE_REP   = {CHANNELS{IDLE_WORD}};
   localparam logic [PW-1:0] LAST_PHASE = PW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [1:0]    r_count;
   logic [DW-1:0] r_head;
   logic [DW-1:0] r_tail;
   logic [PW-1:0] r_phase;
   logic          r_load;
   logic [DW-1:0] r_load_data;
   logic          r_underrun;

   logic          w_last;
   logic          w_push;
   logic          w_pop;
   logic          w_pop_empty;

   assign w_last    = (r_phase == LAST_PHASE);
   assign o_s_ready = (r_state != S_IDLE) && (r_count < 2'd2);
   assign w_push    = i_s_valid && o_s_ready;

   // Next state and pop decisions
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_pop_empty = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_enable) w_state_nxt = S_PRIME;
         end
         S_PRIME: begin
            if (!i_enable) begin
               w_state_nxt = S_IDLE;
            end else if (r_count != 2'd0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // Disable is only honoured at the word boundary, with no pop
            if (w_last) begin
               if (!i_enable) begin
                  w_state_nxt = S_IDLE;
               end else if (r_count != 2'd0) begin
                  w_pop = 1'b1;
               end else begin
                  w_pop_empty = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // 2-entry FIFO; head is always the oldest word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
      end else if (w_state_nxt == S_IDLE) begin
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_s_data;
               else                 r_tail <= i_s_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            // Push with pop only happens at count 1 (ready is low at 2)
            2'b11: r_head <= i_s_data;
            default: ;
         endcase
      end
   end

   // Phase counter, load strobe and load word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase     <= '0;
         r_load      <= 1'b0;
         r_load_data <= IDLE_REP;
      end else begin
         r_load <= w_pop || w_pop_empty;
         if (r_state == S_RUN && w_state_nxt == S_RUN && !w_last)
            r_phase <= r_phase + PW'(1);
         else
            r_phase <= '0;
         if (w_state_nxt == S_IDLE)
            r_load_data <= IDLE_REP;
         else if (w_pop)
            r_load_data <= r_head;
`ifdef SERIALIZER_CTRL_UNDERRUN_EN
         else if (w_pop_empty)
            r_load_data <= IDLE_REP;
`endif
      end
   end

`ifdef SERIALIZER_CTRL_UNDERRUN_EN
   // Sticky underrun; a new event wins over a clear in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 r_underrun <= 1'b0;
      else if (w_pop_empty)    r_underrun <= 1'b1;
      else if (i_underrun_clr) r_underrun <= 1'b0;
   end
`else
   logic w_unused_clr;
   assign w_unused_clr = i_underrun_clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_underrun <= 1'b0;
      else     r_underrun <= 1'b0;
   end
`endif

   assign o_load      = r_load;
   assign o_load_data = r_load_data;
   assign o_phase     = r_phase;
   assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_serializer_ctrl.sv
// Self-checking bench for serializer_ctrl (WIDTH=10, CHANNELS=3).
// Accepted words are queued as they transfer and compared when loaded.
module tb_serializer_ctrl;

   localparam int unsigned W  = 10;
   localparam int unsigned CH = 3;
   localparam int unsigned DW = W * CH;
   localparam int unsigned PW = 4;
   localparam logic [DW-1:0] IDLE_REP = {3{10'b1101010100}};

   logic          clk;
   logic          rst;
   logic          i_enable;
   logic          i_s_valid;
   logic          o_s_ready;
   logic [DW-1:0] i_s_data;
   logic          o_load;
   logic [DW-1:0] o_load_data;
   logic [PW-1:0] o_phase;
   logic          o_underrun;
   logic          i_underrun_clr;

   serializer_ctrl #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_enable       (i_enable),
      .i_s_valid      (i_s_valid),
      .o_s_ready      (o_s_ready),
      .i_s_data       (i_s_data),
      .o_load         (o_load),
      .o_load_data    (o_load_data),
      .o_phase        (o_phase),
      .o_underrun     (o_underrun),
      .i_underrun_clr (i_underrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_pass;
   int            n_total;
   logic [DW-1:0] exp_q[$];
   logic          last_xfer;
   int            since;
   logic [DW-1:0] prev_ld;
   logic          exp_ur;

   // Advance one clock; record an accepted word into the scoreboard
   task automatic step();
      logic xfer;
      xfer = i_s_valid && o_s_ready;
      @(posedge clk);
      #1;
      last_xfer = xfer;
      if (xfer) exp_q.push_back(i_s_data);
   endtask

   task automatic test_reset();
      n_total++; if (o_load !== 1'b0) $display("FAIL rst_load: got %b want 0", o_load); else n_pass++;
      n_total++; if (o_phase !== 4'd0) $display("FAIL rst_phase: got %0d want 0", o_phase); else n_pass++;
      n_total++; if (o_s_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", o_s_ready); else n_pass++;
      n_total++; if (o_underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", o_underrun); else n_pass++;
      n_total++; if (o_load_data !== IDLE_REP) $display("FAIL rst_data: got %h want %h", o_load_data, IDLE_REP); else n_pass++;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++; if (o_s_ready !== 1'b0 || o_load !== 1'b0)
            $display("FAIL idle_hold: ready %b load %b want 0 0", o_s_ready, o_load); else n_pass++;
      end
   endtask

   task automatic test_startup();
      logic [DW-1:0] w0;
      logic [DW-1:0] w1;
      logic [DW-1:0] exp_w;
      w0 = {10'h2AA, 10'h155, 10'h3FF};
      w1 = {10'h0F0, 10'h30C, 10'h1A5};
      i_enable = 1'b1;
      step();
      n_total++; if (o_s_ready !== 1'b1) $display("FAIL prime_ready: got %b want 1", o_s_ready); else n_pass++;
      i_s_valid = 1'b1;
      i_s_data  = w0;
      step();
      i_s_valid = 1'b0;
      n_total++; if (o_load !== 1'b0) $display("FAIL early_load: got %b want 0", o_load); else n_pass++;
      step();
      exp_w = exp_q.pop_front();
      n_total++; if (o_load !== 1'b1) $display("FAIL first_load: got %b want 1", o_load); else n_pass++;
      n_total++; if (o_load_data !== exp_w) $display("FAIL first_data: got %h want %h", o_load_data, exp_w); else n_pass++;
      n_total++; if (o_phase !== 4'd0) $display("FAIL first_phase: got %0d want 0", o_phase); else n_pass++;
      i_s_valid = 1'b1;
      i_s_data  = w1;
      for (int i = 1; i < 10; i++) begin
         step();
         i_s_valid = 1'b0;
         n_total++; if (o_load !== 1'b0 || o_phase !== PW'(i) || o_load_data !== w0)
            $display("FAIL startup_gap: load %b phase %0d data %h want 0 %0d %h", o_load, o_phase, o_load_data, i, w0);
         else n_pass++;
      end
      step();
      exp_w = exp_q.pop_front();
      n_total++; if (o_load !== 1'b1 || o_load_data !== exp_w || o_phase !== 4'd0)
         $display("FAIL second_load: load %b data %h phase %0d want 1 %h 0", o_load, o_load_data, o_phase, exp_w);
      else n_pass++;
      since   = 0;
      prev_ld = o_load_data;
   endtask

   task automatic test_streaming();
      logic [DW-1:0] exp_w;
      int n_xfer;
      int xgap;
      n_xfer    = 0;
      xgap      = 0;
      i_s_valid = 1'b1;
      i_s_data  = DW'($urandom);
      for (int c = 0; c < 60; c++) begin
         step();
         xgap++;
         if (last_xfer) begin
            n_xfer++;
            if (n_xfer >= 4) begin
               n_total++; if (xgap !== 10) $display("FAIL xfer_gap: got %0d want 10", xgap); else n_pass++;
            end
            xgap     = 0;
            i_s_data = DW'($urandom);
         end
         if (o_load === 1'b1) begin
            if (exp_q.size() > (last_xfer ? 1 : 0)) begin
               exp_w = exp_q.pop_front();
            end else begin
`ifdef SERIALIZER_CTRL_UNDERRUN_EN
               exp_w  = IDLE_REP;
               exp_ur = 1'b1;
`else
               exp_w = prev_ld;
`endif
            end
            n_total++; if (o_load_data !== exp_w) $display("FAIL stream_data: got %h want %h", o_load_data, exp_w); else n_pass++;
            n_total++; if (since !== 9) $display("FAIL stream_period: got %0d want 9", since); else n_pass++;
            since = 0;
         end else begin
            since++;
            n_total++; if (o_load_data !== prev_ld) $display("FAIL stream_hold: got %h want %h", o_load_data, prev_ld); else n_pass++;
         end
         n_total++; if (o_phase !== PW'(since)) $display("FAIL stream_phase: got %0d want %0d", o_phase, since); else n_pass++;
         n_total++; if (o_s_ready !== (exp_q.size() < 2)) $display("FAIL stream_ready: got %b want %b", o_s_ready, exp_q.size() < 2); else n_pass++;
         n_total++; if (o_underrun !== exp_ur) $display("FAIL stream_underrun: got %b want %b", o_underrun, exp_ur); else n_pass++;
         prev_ld = o_load_data;
      end
      n_total++; if (n_xfer < 6) $display("FAIL stream_count: got %0d want >=6", n_xfer); else n_pass++;
   endtask

   task automatic test_underrun();
      logic [DW-1:0] exp_w;
      logic [DW-1:0] ld_before;
      i_s_valid = 1'b0;
      for (int c = 0; c < 45; c++) begin
         step();
         if (o_load === 1'b1) begin
            if (exp_q.size() > (last_xfer ? 1 : 0)) begin
               exp_w = exp_q.pop_front();
            end else begin
`ifdef SERIALIZER_CTRL_UNDERRUN_EN
               exp_w  = IDLE_REP;
               exp_ur = 1'b1;
`else
               exp_w = prev_ld;
`endif
            end
            n_total++; if (o_load_data !== exp_w) $display("FAIL drain_data: got %h want %h", o_load_data, exp_w); else n_pass++;
            n_total++; if (since !== 9) $display("FAIL drain_period: got %0d want 9", since); else n_pass++;
            since = 0;
         end else begin
            since++;
         end
         n_total++; if (o_phase !== PW'(since)) $display("FAIL drain_phase: got %0d want %0d", o_phase, since); else n_pass++;
         n_total++; if (o_underrun !== exp_ur) $display("FAIL drain_underrun: got %b want %b", o_underrun, exp_ur); else n_pass++;
         prev_ld = o_load_data;
      end
`ifdef SERIALIZER_CTRL_UNDERRUN_EN
      n_total++; if (o_underrun !== 1'b1) $display("FAIL underrun_set: got %b want 1", o_underrun); else n_pass++;
`else
      n_total++; if (o_underrun !== 1'b0) $display("FAIL underrun_off: got %b want 0", o_underrun); else n_pass++;
`endif
      for (int k = 0; k < 12 && o_phase !== 4'd9; k++) step();
      n_total++; if (o_phase !== 4'd9) $display("FAIL wait_phase9: got %0d want 9", o_phase); else n_pass++;
      ld_before      = o_load_data;
      i_underrun_clr = 1'b1;
      step();
      i_underrun_clr = 1'b0;
`ifdef SERIALIZER_CTRL_UNDERRUN_EN
      exp_w = IDLE_REP;
`else
      exp_w = ld_before;
`endif
      n_total++; if (o_load !== 1'b1 || o_load_data !== exp_w)
         $display("FAIL empty_load: load %b data %h want 1 %h", o_load, o_load_data, exp_w); else n_pass++;
      n_total++; if (o_underrun !== exp_ur) $display("FAIL set_beats_clr: got %b want %b", o_underrun, exp_ur); else n_pass++;
      step();
      n_total++; if (o_underrun !== exp_ur) $display("FAIL underrun_sticky: got %b want %b", o_underrun, exp_ur); else n_pass++;
      i_underrun_clr = 1'b1;
      step();
      i_underrun_clr = 1'b0;
      exp_ur = 1'b0;
      n_total++; if (o_underrun !== 1'b0) $display("FAIL underrun_clr: got %b want 0", o_underrun); else n_pass++;
   endtask

   task automatic test_disable();
      i_s_valid = 1'b1;
      i_s_data  = DW'($urandom);
      for (int k = 0; k < 12 && o_phase !== 4'd3; k++) begin
         step();
         if (last_xfer) i_s_data = DW'($urandom);
      end
      n_total++; if (o_phase !== 4'd3) $display("FAIL wait_phase3: got %0d want 3", o_phase); else n_pass++;
      i_enable = 1'b0;
      for (int i = 4; i < 10; i++) begin
         step();
         if (last_xfer) i_s_data = DW'($urandom);
         n_total++; if (o_load !== 1'b0 || o_phase !== PW'(i))
            $display("FAIL disable_tail: load %b phase %0d want 0 %0d", o_load, o_phase, i); else n_pass++;
      end
      n_total++; if (o_s_ready !== 1'b0) $display("FAIL disable_full: got %b want 0", o_s_ready); else n_pass++;
      step();
      n_total++; if (o_load !== 1'b0 || o_phase !== 4'd0)
         $display("FAIL disable_stop: load %b phase %0d want 0 0", o_load, o_phase); else n_pass++;
      n_total++; if (o_s_ready !== 1'b0) $display("FAIL disable_ready: got %b want 0", o_s_ready); else n_pass++;
      n_total++; if (o_load_data !== IDLE_REP) $display("FAIL disable_data: got %h want %h", o_load_data, IDLE_REP); else n_pass++;
      exp_q.delete();
      i_s_valid = 1'b0;
      i_enable  = 1'b1;
      step();
      n_total++; if (o_s_ready !== 1'b1) $display("FAIL reprime_ready: got %b want 1", o_s_ready); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++; if (o_load !== 1'b0) $display("FAIL flush_no_load: got %b want 0", o_load); else n_pass++;
      end
   endtask

   task automatic test_reset_midrun();
      logic found;
      found     = 1'b0;
      i_s_valid = 1'b1;
      i_s_data  = DW'($urandom);
      for (int k = 0; k < 40; k++) begin
         step();
         if (last_xfer) i_s_data = DW'($urandom);
         if (o_s_ready === 1'b0 && o_phase >= 4'd2 && o_phase <= 4'd8) begin
            found = 1'b1;
            break;
         end
      end
      n_total++; if (found !== 1'b1) $display("FAIL reach_full: got %b want 1", found); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (o_load !== 1'b0) $display("FAIL mrst_load: got %b want 0", o_load); else n_pass++;
      n_total++; if (o_phase !== 4'd0) $display("FAIL mrst_phase: got %0d want 0", o_phase); else n_pass++;
      n_total++; if (o_s_ready !== 1'b0) $display("FAIL mrst_ready: got %b want 0", o_s_ready); else n_pass++;
      n_total++; if (o_underrun !== 1'b0) $display("FAIL mrst_underrun: got %b want 0", o_underrun); else n_pass++;
      n_total++; if (o_load_data !== IDLE_REP) $display("FAIL mrst_data: got %h want %h", o_load_data, IDLE_REP); else n_pass++;
      i_enable  = 1'b0;
      i_s_valid = 1'b0;
      exp_q.delete();
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++; if (o_s_ready !== 1'b0 || o_load !== 1'b0)
            $display("FAIL post_rst_idle: ready %b load %b want 0 0", o_s_ready, o_load); else n_pass++;
      end
      i_enable = 1'b1;
      step();
      n_total++; if (o_s_ready !== 1'b1) $display("FAIL post_rst_prime: got %b want 1", o_s_ready); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_pass         = 0;
      n_total        = 0;
      last_xfer      = 1'b0;
      since          = 0;
      prev_ld        = IDLE_REP;
      exp_ur         = 1'b0;
      rst            = 1'b1;
      i_enable       = 1'b0;
      i_s_valid      = 1'b0;
      i_s_data       = '0;
      i_underrun_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_startup();
      test_streaming();
      test_underrun();
      test_disable();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
